// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks (two_power_mod, montgomery_mul).
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 256;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_CALC,
    STATE_FINAL,
    STATE_DONE
  } mont_state_t;

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery round: r' = (r + a_k*B + q*N) / 2, with q chosen to make the sum even.
module mont_step
  import rsa_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = RSA_WIDTH
) (
  input  logic [MOD_WIDTH+1:0] i_r,
  input  logic [MOD_WIDTH-1:0] i_b,
  input  logic [MOD_WIDTH-1:0] i_n,
  input  logic                 i_a_bit,
  output logic [MOD_WIDTH+1:0] o_r
);

  logic [MOD_WIDTH+1:0] w_t1;
  logic [MOD_WIDTH+1:0] w_t2;

  // Two guard bits: r < 2N keeps every intermediate below 4N.
  always_comb begin
    w_t1 = i_r + (i_a_bit ? {2'b00, i_b} : '0);
    w_t2 = w_t1 + (w_t1[0] ? {2'b00, i_n} : '0);
    o_r  = w_t2 >> 1;
  end

endmodule

// File: rtl/montgomery_mul.sv
// Bit-serial radix-2 Montgomery multiplier: o_out = A * B * 2^-MOD_WIDTH mod N.
module montgomery_mul
  import rsa_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = RSA_WIDTH,
  parameter int unsigned CNT_WIDTH = $clog2(MOD_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_a,
  input  logic [MOD_WIDTH-1:0] i_b,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out
);

  mont_state_t          r_state;
  mont_state_t          w_state_nxt;
  logic [MOD_WIDTH+1:0] r_acc;
  logic [MOD_WIDTH+1:0] w_acc_step;
  logic [MOD_WIDTH-1:0] r_a;
  logic [MOD_WIDTH-1:0] r_b;
  logic [MOD_WIDTH-1:0] r_n;
  logic [MOD_WIDTH-1:0] r_out;
  logic [MOD_WIDTH-1:0] w_red;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_in_fire;
  logic                 w_last;

  assign w_in_fire = i_valid && i_ready;
  assign w_last    = (r_cnt == CNT_WIDTH'(MOD_WIDTH - 1));
  assign o_out     = r_out;

  // Final result is below N, so the subtraction is exact in MOD_WIDTH bits.
  assign w_red = (r_acc >= {2'b00, r_n}) ? (r_acc[MOD_WIDTH-1:0] - r_n)
                                         : r_acc[MOD_WIDTH-1:0];

  mont_step #(
    .MOD_WIDTH(MOD_WIDTH)
  ) u_step (
    .i_r    (r_acc),
    .i_b    (r_b),
    .i_n    (r_n),
    .i_a_bit(r_a[0]),
    .o_r    (w_acc_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    i_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      STATE_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) w_state_nxt = STATE_CALC;
      end
      STATE_CALC: begin
        if (w_last) w_state_nxt = STATE_FINAL;
      end
      STATE_FINAL: w_state_nxt = STATE_DONE;
      STATE_DONE: begin
        o_valid = 1'b1;
        if (o_ready) w_state_nxt = STATE_IDLE;
      end
      default: w_state_nxt = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STATE_IDLE;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        STATE_IDLE: begin
          if (w_in_fire) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_n   <= i_modulus;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        STATE_CALC: begin
          // A is consumed LSB first by shifting the latched copy.
          r_acc <= w_acc_step;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        STATE_FINAL: r_out <= w_red;
        default: ;
      endcase
    end
  end

endmodule
